// File: rtl/hist_bin_accumulator.sv
// hist_bin_accumulator
//   Bins each valid sample by its top BIN_BITS bits into a bank of per-bin
//   counters. A small control FSM sequences ACCUM (counting), CLEAR (one bin
//   zeroed per cycle) and DUMP (serial readout of every bin, one per cycle).
//   Optional build macro: HIST_SATURATE_EN -- bin counters saturate at their
//   maximum instead of wrapping. The overflow flag behaves the same either way.
module hist_bin_accumulator #(
  parameter int SAMPLE_W = 8,
  parameter int BIN_BITS = 4,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                clear_req,
  input  logic                dump_req,
  output logic [COUNT_W-1:0]  dump_data,
  output logic [BIN_BITS-1:0] dump_bin,
  output logic                dump_valid,
  output logic                busy,
  output logic                overflow,
  output logic                dropped
);

  localparam int                  NUM_BINS  = 2 ** BIN_BITS;
  localparam logic [BIN_BITS-1:0] LAST_BIN  = BIN_BITS'(NUM_BINS - 1);
  localparam logic [COUNT_W-1:0]  COUNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_CLEAR,
    ST_DUMP
  } state_e;

  state_e              state_q, state_d;
  logic [BIN_BITS-1:0] sweep_q;
  logic [COUNT_W-1:0]  bins_q [NUM_BINS];
  logic [BIN_BITS-1:0] idx;
  logic [BIN_BITS-1:0] next_bin;
  logic                accum_hit;

  // Counter increment; the build decides between saturating and wrapping.
  function automatic logic [COUNT_W-1:0] bin_inc(input logic [COUNT_W-1:0] v);
`ifdef HIST_SATURATE_EN
    return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
`else
    return v + COUNT_W'(1);
`endif
  endfunction

  assign idx       = sample_in[SAMPLE_W-1 -: BIN_BITS];
  assign next_bin  = dump_bin + BIN_BITS'(1);
  assign accum_hit = (state_q == ST_ACCUM) && sample_valid;
  assign busy      = (state_q != ST_ACCUM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update together from the pre-edge values.
    if (!rst_n) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic: clear wins over dump; requests while busy are ignored.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (clear_req)     state_d = ST_CLEAR;
        else if (dump_req) state_d = ST_DUMP;
      end
      ST_CLEAR: if (sweep_q == LAST_BIN)  state_d = ST_ACCUM;
      ST_DUMP:  if (dump_bin == LAST_BIN) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  // Bin bank: count in ACCUM, zero one bin per cycle in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the bank is small and must read zero straight out of reset, so
    // it is reset here; larger banks would normally rely on a CLEAR sweep.
    if (!rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
    end else if (accum_hit) begin
      bins_q[idx] <= bin_inc(bins_q[idx]);
    end else if (state_q == ST_CLEAR) begin
      bins_q[sweep_q] <= '0;
    end
  end

  // Sweep index, registered dump outputs and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q    <= '0;
      dump_data  <= '0;
      dump_bin   <= '0;
      dump_valid <= 1'b0;
      overflow   <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      if (accum_hit && (bins_q[idx] == COUNT_MAX)) overflow <= 1'b1;
      if (sample_valid && busy)                    dropped  <= 1'b1;
      unique case (state_q)
        ST_ACCUM: begin
          sweep_q <= '0;
          if (!clear_req && dump_req) begin
            // Bin 0 leaves on this edge, so forward a same-cycle sample into it.
            dump_valid <= 1'b1;
            dump_bin   <= '0;
            dump_data  <= (accum_hit && (idx == '0)) ? bin_inc(bins_q[0]) : bins_q[0];
          end
        end
        ST_CLEAR: begin
          if (sweep_q == LAST_BIN) begin
            // Leaving CLEAR wipes the sticky flags, overriding any set above.
            sweep_q  <= '0;
            overflow <= 1'b0;
            dropped  <= 1'b0;
          end else begin
            sweep_q <= sweep_q + BIN_BITS'(1);
          end
        end
        ST_DUMP: begin
          if (dump_bin == LAST_BIN) begin
            dump_valid <= 1'b0;
          end else begin
            dump_bin  <= next_bin;
            dump_data <= bins_q[next_bin];
          end
        end
        default: sweep_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_bin_accumulator.sv
// tb_hist_bin_accumulator
//   Randomized self-checking bench. The reference model is a plain integer
//   array of bin counts plus two sticky flags, updated per accepted sample
//   and compared against every serial dump.
module tb_hist_bin_accumulator;

  localparam int SAMPLE_W = 8;
  localparam int BIN_BITS = 4;
  localparam int COUNT_W  = 8;
  localparam int NUM_BINS = 16;
  localparam int MAX_CNT  = 255;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [SAMPLE_W-1:0] sample_in = '0;
  logic                sample_valid = 1'b0;
  logic                clear_req = 1'b0;
  logic                dump_req = 1'b0;
  logic [COUNT_W-1:0]  dump_data;
  logic [BIN_BITS-1:0] dump_bin;
  logic                dump_valid;
  logic                busy;
  logic                overflow;
  logic                dropped;

  int n_checks = 0;
  int n_fail   = 0;

  int m_bins [NUM_BINS];
  bit m_ovf;
  bit m_drp;

  hist_bin_accumulator #(
    .SAMPLE_W(SAMPLE_W),
    .BIN_BITS(BIN_BITS),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .clear_req   (clear_req),
    .dump_req    (dump_req),
    .dump_data   (dump_data),
    .dump_bin    (dump_bin),
    .dump_valid  (dump_valid),
    .busy        (busy),
    .overflow    (overflow),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_BINS; i++) m_bins[i] = 0;
    m_ovf = 1'b0;
    m_drp = 1'b0;
  endfunction

  // One accepted sample: bin = top four bits of the sample value.
  function automatic void model_count(input logic [SAMPLE_W-1:0] v);
    int b;
    b = int'(v) / (2 ** (SAMPLE_W - BIN_BITS));
    if (m_bins[b] == MAX_CNT) begin
      m_ovf = 1'b1;
`ifdef HIST_SATURATE_EN
      m_bins[b] = MAX_CNT;
`else
      m_bins[b] = 0;
`endif
    end else begin
      m_bins[b] = m_bins[b] + 1;
    end
  endfunction

  task automatic feed(input logic [SAMPLE_W-1:0] v, input bit valid);
    sample_in    = v;
    sample_valid = valid;
    if (valid) model_count(v);
    tick();
    sample_valid = 1'b0;
  endtask

  // Request a dump and compare all 16 readout cycles against the model.
  // hold_busy keeps sample_valid and dump_req asserted during the readout.
  task automatic do_dump(input bit hold_busy, input bit with_sample);
    dump_req     = 1'b1;
    sample_in    = SAMPLE_W'($urandom);
    sample_valid = with_sample;
    if (with_sample) model_count(sample_in);
    tick();
    dump_req     = 1'b0;
    sample_valid = 1'b0;
    for (int k = 0; k < NUM_BINS; k++) begin
      check("dump_valid", 32'(dump_valid), 32'd1);
      check("dump_busy", 32'(busy), 32'd1);
      check("dump_bin", 32'(dump_bin), 32'(k));
      check("dump_data", 32'(dump_data), 32'(m_bins[k]));
      sample_in    = SAMPLE_W'($urandom);
      sample_valid = hold_busy;
      dump_req     = hold_busy;
      if (hold_busy) m_drp = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    dump_req     = 1'b0;
    check("dump_end_valid", 32'(dump_valid), 32'd0);
    check("dump_end_busy", 32'(busy), 32'd0);
    check("dump_bin_hold", 32'(dump_bin), 32'(NUM_BINS - 1));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("dropped", 32'(dropped), 32'(m_drp));
  endtask

  // Request a clear (optionally together with a dump that must be discarded).
  task automatic do_clear(input bit also_dump);
    clear_req    = 1'b1;
    dump_req     = also_dump;
    sample_in    = SAMPLE_W'($urandom);
    sample_valid = 1'b1;
    model_count(sample_in);
    tick();
    clear_req    = 1'b0;
    dump_req     = 1'b0;
    for (int k = 0; k < NUM_BINS; k++) begin
      check("clear_busy", 32'(busy), 32'd1);
      check("clear_no_dump", 32'(dump_valid), 32'd0);
      sample_in    = SAMPLE_W'($urandom);
      sample_valid = 1'($urandom_range(0, 1));
      tick();
    end
    sample_valid = 1'b0;
    model_reset();
    check("clear_end_busy", 32'(busy), 32'd0);
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_dropped", 32'(dropped), 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_dump_bin", 32'(dump_bin), 32'd0);
    check("rst_dump_data", 32'(dump_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: three samples into bin 1, then dump.
    feed(8'h12, 1'b1);
    feed(8'h1F, 1'b1);
    feed(8'h10, 1'b1);
    check("t1_model_bin1", 32'(m_bins[1]), 32'd3);
    do_dump(1'b0, 1'b0);

    // 2: free-running counter 0..255 -> every bin gets 16 more.
    do_clear(1'b0);
    for (int i = 0; i < 256; i++) feed(SAMPLE_W'(i), 1'b1);
    do_dump(1'b0, 1'b0);

    // 3: 256 hits on bin 10 -> counter wraps or saturates, overflow set.
    do_clear(1'b0);
    for (int i = 0; i < 256; i++) feed(8'hA5, 1'b1);
    do_dump(1'b0, 1'b0);

    // 4: clear and dump in the same cycle -> clear wins, bins zero.
    feed(8'h33, 1'b1);
    do_clear(1'b1);
    do_dump(1'b0, 1'b0);

    // 5: samples and dump requests held during a dump are discarded.
    for (int i = 0; i < 40; i++) feed(SAMPLE_W'($urandom), 1'b1);
    do_dump(1'b1, 1'b0);
    do_dump(1'b0, 1'b0);

    // Randomized rounds, including a sample in the dump-request cycle.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(20, 200));
      for (int i = 0; i < n; i++)
        feed(SAMPLE_W'($urandom), 1'($urandom_range(0, 3) != 0));
      feed(8'h07, 1'b1);
      do_dump(1'($urandom_range(0, 1)), 1'b1);
      if (r % 2 == 1) do_clear(1'($urandom_range(0, 1)));
    end

    // 6: reset asserted in the fifth dump cycle.
    for (int i = 0; i < 30; i++) feed(SAMPLE_W'($urandom), 1'b1);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t6_mid_dump_bin", 32'(dump_bin), 32'd4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_dump_valid", 32'(dump_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_dump_bin", 32'(dump_bin), 32'd0);
    check("t6_rst_dump_data", 32'(dump_data), 32'd0);
    check("t6_rst_overflow", 32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_idle_valid", 32'(dump_valid), 32'd0);
    do_dump(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
